hp0_axi_rr_arbiter: RTL and testbench
=====================================

Name: hp0_axi_rr_arbiter

Overview:
- Shares the single HP0 AXI4 master port between two PL requesters (index 0, 1), such as a DMA engine and a cache-miss unit.
- Write and read directions are arbitrated independently, each by a round-robin FSM that allows one outstanding burst per direction.
- The block sits between the requesters and the hp0_axi_* pins of top_zynq.
- It routes B and R responses back to the granted requester and regenerates WLAST from its own beat counter.

Parameters:
- addr_width_p, 32, AXI address width.
- data_width_p, 32, AXI data width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- s_awaddr/s_araddr  in  2*addr_width_p  packed per-requester addresses; requester i occupies bits [i*addr_width_p +: addr_width_p].
- s_awlen/s_arlen  in  16  packed 8-bit burst lengths.
- s_awsize/s_arsize  in  6  packed 3-bit sizes.
- s_awburst/s_arburst  in  4  packed 2-bit burst types.
- s_awvalid/s_arvalid  in  2  per-requester address valid.
- s_awready/s_arready  out  2  per-requester address ready.
- s_wdata  in  2*data_width_p  packed write data.
- s_wstrb  in  2*data_width_p/8  packed write strobes.
- s_wvalid  in  2  write data valid.
- s_wready  out  2  write data ready.
- s_bvalid  out  2  write response valid.
- s_bready  in  2  write response ready.
- s_bresp  out  2  write response, shared.
- s_rdata  out  data_width_p  read data, shared.
- s_rresp  out  2  read response, shared.
- s_rlast  out  1  last read beat, shared.
- s_rvalid  out  2  read data valid.
- s_rready  in  2  read data ready.
- m_axi_aw*/w*/b*/ar*/r*  mixed  per HP0 AXI4 (awid/arid 6, len 8, wid 6)  master port to hp0_axi_*; widths are addr_width_p / data_width_p.

Behaviour:
- Clocking/reset: one clock, aclk. Reset is aresetn: asynchronous, active-low.
- Reset state:
  - Both FSMs go to IDLE.
  - Both RR pointers are 0, so requester 0 has priority first.
  - Beat counter is 0.
  - All m_*valid, m_bready, m_rready, s_*ready and s_*valid outputs are 0.
- Reset asserted mid-burst: the in-flight burst is abandoned with no completion to the requester. Reset must only be applied together with the PS reset.
- Constant master fields:
  - m_awid/m_arid/m_wid = {5'b0, grant}.
  - m_*lock = 0, m_*cache = 4'b0011, m_*prot = 3'b000, m_*qos = 0.
- Write FSM states: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE, any s_awvalid set: wgrant is latched. With both requesting, the winner is the requester != wlast_grant. Captured: awlen into wlen_r; beat counter cleared. Next state W_ADDR. No ready is asserted in W_IDLE, so AW appears on the master one cycle after request.
  - W_ADDR: m_awvalid = 1 and the AW fields are muxed from wgrant. s_awready[wgrant] = m_awready. Handshake -> W_DATA.
  - W_DATA: m_wvalid = s_wvalid[wgrant] and s_wready[wgrant] = m_wready; data and strb are muxed. m_wlast = (beat == wlen_r). Each W handshake increments beat. The handshake with m_wlast = 1 -> W_RESP. The requester's own wlast is not used.
  - W_RESP: s_bvalid[wgrant] = m_bvalid, m_bready = s_bready[wgrant], s_bresp = m_bresp. B handshake -> W_IDLE, and wlast_grant is set to wgrant.
- Read FSM states: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - Arbitration and the AR phase work the same way with rgrant / rlast_grant.
  - R_DATA: s_rvalid[rgrant] = m_rvalid, m_rready = s_rready[rgrant]; rdata, rresp and rlast pass through. The handshake with m_rlast = 1 -> R_IDLE and updates rlast_grant.
- Non-granted requester: all its ready/valid outputs stay 0. It may hold its valid indefinitely.
- Concurrency: read and write FSMs are fully independent. Simultaneous read and write grants to different requesters are legal.
- Lone requester: a lone requester is granted regardless of the pointer.
- Back-to-back bursts: a new grant cannot be issued in the cycle of the completing handshake, which gives a minimum 1 idle cycle between bursts.
- Beat counter: 8-bit; awlen = 255 gives 256 beats with no wrap before m_wlast.
- Response codes: bresp/rresp are forwarded unmodified; the arbiter never retries.

Test Plan:
- Single write: requester 1 issues awaddr 0x1000_0040, awlen 3, 4 beats data 0xA0..0xA3 -> 1 cycle later m_awvalid=1, m_awid=1. m_wlast=1 on the 4th beat only. s_bvalid=2'b10 on the master B.
- Contention: both requesters assert awvalid the same cycle after reset -> grant order is 0, 1, 0, 1 over 4 single-beat writes. Non-granted s_awready stays 0.
- Stall: m_wready toggled 1,0,0,1 during a 2-beat burst -> exactly 2 W handshakes. Beat count is correct and data is not duplicated.
- Concurrent directions: requester 0 read of arlen 7 while requester 1 writes -> both complete independently. s_rvalid=2'b01 for 8 beats; s_rlast=1 on beat 8.
- Long burst: awlen 255 -> 256 beats. m_wlast=1 on beat 256 only, then W_RESP.
- Reset mid-burst: aresetn dropped during beat 2 of 4 -> next edge has all valids/readys 0 and both FSMs idle. After release, requester 0 wins first.

Source files
------------

// File: rtl/hp0_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hp0_axi_rr_arbiter
// Purpose  : Two-requester round-robin arbiter onto the HP0 AXI4 master port,
//            with independent write and read arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module hp0_axi_rr_arbiter #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    // requester write address / data / response
    input  logic [2*addr_width_p-1:0]     s_awaddr,
    input  logic [15:0]                   s_awlen,
    input  logic [5:0]                    s_awsize,
    input  logic [3:0]                    s_awburst,
    input  logic [1:0]                    s_awvalid,
    output logic [1:0]                    s_awready,
    input  logic [2*data_width_p-1:0]     s_wdata,
    input  logic [2*data_width_p/8-1:0]   s_wstrb,
    input  logic [1:0]                    s_wvalid,
    output logic [1:0]                    s_wready,
    output logic [1:0]                    s_bvalid,
    input  logic [1:0]                    s_bready,
    output logic [1:0]                    s_bresp,
    // requester read address / data
    input  logic [2*addr_width_p-1:0]     s_araddr,
    input  logic [15:0]                   s_arlen,
    input  logic [5:0]                    s_arsize,
    input  logic [3:0]                    s_arburst,
    input  logic [1:0]                    s_arvalid,
    output logic [1:0]                    s_arready,
    output logic [data_width_p-1:0]       s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic [1:0]                    s_rvalid,
    input  logic [1:0]                    s_rready,
    // HP0 master write channels
    output logic [5:0]                    m_axi_awid,
    output logic [addr_width_p-1:0]       m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awlock,
    output logic [3:0]                    m_axi_awcache,
    output logic [2:0]                    m_axi_awprot,
    output logic [3:0]                    m_axi_awqos,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [5:0]                    m_axi_wid,
    output logic [data_width_p-1:0]       m_axi_wdata,
    output logic [data_width_p/8-1:0]     m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    // HP0 master read channels
    output logic [5:0]                    m_axi_arid,
    output logic [addr_width_p-1:0]       m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arlock,
    output logic [3:0]                    m_axi_arcache,
    output logic [2:0]                    m_axi_arprot,
    output logic [3:0]                    m_axi_arqos,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [data_width_p-1:0]       m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int         STRB_W  = data_width_p / 8;
    localparam logic [3:0] C_CACHE = 4'b0011;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    wstate_t    wstate_q, wstate_d;
    rstate_t    rstate_q, rstate_d;
    logic       wgrant_q, wgrant_d;
    logic       rgrant_q, rgrant_d;
    // prio_q holds the requester that wins a tie; reset value 0 favours requester 0
    logic       wprio_q, wprio_d;
    logic       rprio_q, rprio_d;
    logic [7:0] wlen_q, wlen_d;
    logic [7:0] beat_q, beat_d;

    logic [1:0] wsel, rsel;
    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign wsel = {wgrant_q, ~wgrant_q};
    assign rsel = {rgrant_q, ~rgrant_q};

    // ---------------- write channel datapath ----------------
    assign m_axi_awvalid = (wstate_q == W_ADDR);
    assign m_axi_awid    = {5'b0, wgrant_q};
    assign m_axi_awaddr  = wgrant_q ? s_awaddr[addr_width_p +: addr_width_p] : s_awaddr[0 +: addr_width_p];
    assign m_axi_awlen   = wgrant_q ? s_awlen[15:8]   : s_awlen[7:0];
    assign m_axi_awsize  = wgrant_q ? s_awsize[5:3]   : s_awsize[2:0];
    assign m_axi_awburst = wgrant_q ? s_awburst[3:2]  : s_awburst[1:0];
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = C_CACHE;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;

    assign m_axi_wid     = {5'b0, wgrant_q};
    assign m_axi_wdata   = wgrant_q ? s_wdata[data_width_p +: data_width_p] : s_wdata[0 +: data_width_p];
    assign m_axi_wstrb   = wgrant_q ? s_wstrb[STRB_W +: STRB_W] : s_wstrb[0 +: STRB_W];
    assign m_axi_wvalid  = (wstate_q == W_DATA) & s_wvalid[wgrant_q];
    // WLAST comes from our own beat count; requesters never supply one
    assign m_axi_wlast   = (wstate_q == W_DATA) & (beat_q == wlen_q);
    assign m_axi_bready  = (wstate_q == W_RESP) & s_bready[wgrant_q];

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid  & m_axi_wready;
    assign b_hs  = m_axi_bvalid  & m_axi_bready;

    assign s_awready = wsel & {2{aw_hs}};
    assign s_wready  = wsel & {2{(wstate_q == W_DATA) & m_axi_wready}};
    assign s_bvalid  = wsel & {2{(wstate_q == W_RESP) & m_axi_bvalid}};
    assign s_bresp   = m_axi_bresp;

    // ---------------- read channel datapath ----------------
    assign m_axi_arvalid = (rstate_q == R_ADDR);
    assign m_axi_arid    = {5'b0, rgrant_q};
    assign m_axi_araddr  = rgrant_q ? s_araddr[addr_width_p +: addr_width_p] : s_araddr[0 +: addr_width_p];
    assign m_axi_arlen   = rgrant_q ? s_arlen[15:8]   : s_arlen[7:0];
    assign m_axi_arsize  = rgrant_q ? s_arsize[5:3]   : s_arsize[2:0];
    assign m_axi_arburst = rgrant_q ? s_arburst[3:2]  : s_arburst[1:0];
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = C_CACHE;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_rready  = (rstate_q == R_DATA) & s_rready[rgrant_q];

    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rvalid  & m_axi_rready;

    assign s_arready = rsel & {2{ar_hs}};
    assign s_rvalid  = rsel & {2{(rstate_q == R_DATA) & m_axi_rvalid}};
    assign s_rdata   = m_axi_rdata;
    assign s_rresp   = m_axi_rresp;
    assign s_rlast   = m_axi_rlast;

    // ---------------- write FSM ----------------
    always_comb begin
        wstate_d = wstate_q;
        wgrant_d = wgrant_q;
        wprio_d  = wprio_q;
        wlen_d   = wlen_q;
        beat_d   = beat_q;
        case (wstate_q)
            W_IDLE: begin
                if (|s_awvalid) begin
                    wgrant_d = (&s_awvalid) ? wprio_q : s_awvalid[1];
                    wlen_d   = wgrant_d ? s_awlen[15:8] : s_awlen[7:0];
                    beat_d   = 8'd0;
                    wstate_d = W_ADDR;
                end
            end
            W_ADDR: begin
                if (aw_hs) wstate_d = W_DATA;
            end
            W_DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (m_axi_wlast) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wprio_d  = ~wgrant_q;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // ---------------- read FSM ----------------
    always_comb begin
        rstate_d = rstate_q;
        rgrant_d = rgrant_q;
        rprio_d  = rprio_q;
        case (rstate_q)
            R_IDLE: begin
                if (|s_arvalid) begin
                    rgrant_d = (&s_arvalid) ? rprio_q : s_arvalid[1];
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (ar_hs) rstate_d = R_DATA;
            end
            R_DATA: begin
                if (r_hs && m_axi_rlast) begin
                    rprio_d  = ~rgrant_q;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q <= W_IDLE;
            wgrant_q <= 1'b0;
            wprio_q  <= 1'b0;
            wlen_q   <= 8'd0;
            beat_q   <= 8'd0;
            rstate_q <= R_IDLE;
            rgrant_q <= 1'b0;
            rprio_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wgrant_q <= wgrant_d;
            wprio_q  <= wprio_d;
            wlen_q   <= wlen_d;
            beat_q   <= beat_d;
            rstate_q <= rstate_d;
            rgrant_q <= rgrant_d;
            rprio_q  <= rprio_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hp0_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hp0_axi_rr_arbiter
// Purpose  : Directed self-checking bench for hp0_axi_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hp0_axi_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [2*AW-1:0] s_awaddr, s_araddr;
    logic [15:0]     s_awlen, s_arlen;
    logic [5:0]      s_awsize, s_arsize;
    logic [3:0]      s_awburst, s_arburst;
    logic [1:0]      s_awvalid, s_arvalid, s_awready, s_arready;
    logic [2*DW-1:0] s_wdata;
    logic [2*DW/8-1:0] s_wstrb;
    logic [1:0]      s_wvalid, s_wready, s_bvalid, s_bready, s_bresp;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp, s_rvalid, s_rready;
    logic            s_rlast;
    logic [5:0]      m_axi_awid, m_axi_arid, m_axi_wid;
    logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
    logic [7:0]      m_axi_awlen, m_axi_arlen;
    logic [2:0]      m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]      m_axi_awburst, m_axi_arburst;
    logic            m_axi_awlock, m_axi_arlock;
    logic [3:0]      m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
    logic            m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]      m_axi_bresp, m_axi_rresp;
    logic            m_axi_bvalid, m_axi_bready;
    logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int tests_run    = 0;
    int tests_failed = 0;

    hp0_axi_rr_arbiter #(.addr_width_p(AW), .data_width_p(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic clear_inputs();
        s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
        s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = '0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = '0; s_bready = '0; s_rready = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = '0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;
    endtask

    task automatic check_all_idle(input string tag);
        check(tag, {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                    s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 64'd0);
    endtask

    // Waits (bounded) for AW, checks the granted fields, then completes the handshake.
    task automatic aw_phase(input int req, input logic [7:0] len, input logic [31:0] addr);
        logic [1:0] sel;
        int n;
        sel = '0; sel[req] = 1'b1; n = 0;
        while (!m_axi_awvalid && n < 8) begin step(); n++; end
        check("aw_valid", m_axi_awvalid, 1);
        check("aw_id", m_axi_awid, req);
        check("aw_addr", m_axi_awaddr, addr);
        check("aw_len", m_axi_awlen, len);
        m_axi_awready = 1; #1;
        check("aw_ready", s_awready, sel);
        step();
        m_axi_awready = 0;
    endtask

    // Drives len+1 beats; with stall the slave ready pattern is 1,0,0,1 repeating.
    task automatic w_phase(input int req, input logic [7:0] len, input logic [31:0] dbase,
                           input bit stall, output int cycles);
        int beat;
        beat = 0; cycles = 0;
        s_wvalid[req] = 1'b1;
        while (beat <= int'(len) && cycles < 2000) begin
            s_wdata[req*DW +: DW] = dbase + 32'(beat);
            m_axi_wready = stall ? ((cycles % 4 == 0) || (cycles % 4 == 3)) : 1'b1;
            #1;
            if (m_axi_wvalid && m_axi_wready) begin
                check("w_data", m_axi_wdata, dbase + 32'(beat));
                check("w_last", m_axi_wlast, (beat == int'(len)) ? 1 : 0);
                check("w_ready", s_wready[req], 1);
                beat++;
            end
            cycles++;
            step();
        end
        check("w_beats", beat, int'(len) + 1);
        check("w_id", m_axi_wid, req);
        s_wvalid[req] = 1'b0;
        m_axi_wready = 0;
    endtask

    task automatic b_phase(input int req, input logic [1:0] resp);
        logic [1:0] sel;
        sel = '0; sel[req] = 1'b1;
        m_axi_bvalid = 1; m_axi_bresp = resp; s_bready = sel;
        #1;
        check("b_valid", s_bvalid, sel);
        check("b_ready", m_axi_bready, 1);
        check("b_resp", s_bresp, resp);
        step();
        m_axi_bvalid = 0; s_bready = '0;
        #1;
        check("b_done", s_bvalid, 0);
    endtask

    initial begin
        int cyc;
        clear_inputs();
        aresetn = 0;
        repeat (3) @(posedge aclk);
        #2 aresetn = 1;
        #1;
        check_all_idle("reset_idle");
        check("reset_awcache", m_axi_awcache, 4'b0011);
        check("reset_arcache", m_axi_arcache, 4'b0011);

        // single write from requester 1
        s_awvalid = 2'b10; s_awaddr[AW +: AW] = 32'h1000_0040; s_awlen[15:8] = 8'd3;
        s_awsize[5:3] = 3'b010; s_awburst[3:2] = 2'b01;
        #1;
        check("aw_latency0", m_axi_awvalid, 0);
        step();
        check("aw_latency1", m_axi_awvalid, 1);
        check("aw_size", m_axi_awsize, 3'b010);
        check("aw_burst", m_axi_awburst, 2'b01);
        check("aw_const", {m_axi_awlock, m_axi_awprot, m_axi_awqos}, 0);
        aw_phase(1, 8'd3, 32'h1000_0040);
        s_awvalid = 2'b00;
        w_phase(1, 8'd3, 32'hA0, 1'b0, cyc);
        b_phase(1, 2'b10);

        // contention: both hold AWVALID, grants alternate starting at 0
        s_awaddr = {32'h2000_0100, 32'h2000_0000}; s_awlen = '0; s_awvalid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            aw_phase(k % 2, 8'd0, (k % 2 == 1) ? 32'h2000_0100 : 32'h2000_0000);
            if (k == 2) s_awvalid[0] = 1'b0;
            if (k == 3) s_awvalid[1] = 1'b0;
            w_phase(k % 2, 8'd0, 32'hC0 + 32'(k), 1'b0, cyc);
            b_phase(k % 2, 2'b00);
        end

        // stall: wready 1,0,0,1 over a 2-beat burst
        s_awvalid = 2'b01; s_awaddr[0 +: AW] = 32'h5000_0000; s_awlen[7:0] = 8'd1;
        aw_phase(0, 8'd1, 32'h5000_0000);
        s_awvalid = 2'b00;
        w_phase(0, 8'd1, 32'hB0, 1'b1, cyc);
        check("stall_cycles", cyc, 4);
        b_phase(0, 2'b00);

        // concurrent: requester 0 reads 8 beats while requester 1 writes 2
        s_arvalid = 2'b01; s_araddr[0 +: AW] = 32'h3000_0000; s_arlen[7:0] = 8'd7;
        s_awvalid = 2'b10; s_awaddr[AW +: AW] = 32'h4000_0000; s_awlen[15:8] = 8'd1;
        step();
        check("cc_arvalid", m_axi_arvalid, 1);
        check("cc_arid", m_axi_arid, 0);
        check("cc_arlen", m_axi_arlen, 7);
        check("cc_awid", m_axi_awid, 1);
        m_axi_arready = 1; m_axi_awready = 1; #1;
        check("cc_arready", s_arready, 2'b01);
        check("cc_awready", s_awready, 2'b10);
        step();
        m_axi_arready = 0; m_axi_awready = 0; s_arvalid = '0; s_awvalid = '0;
        s_rready = 2'b01;
        for (int i = 0; i < 8; i++) begin
            m_axi_rvalid = 1; m_axi_rdata = 32'hD0 + 32'(i); m_axi_rlast = (i == 7);
            s_wvalid = (i < 2) ? 2'b10 : 2'b00;
            s_wdata[DW +: DW] = 32'hE0 + 32'(i);
            m_axi_wready = (i < 2);
            m_axi_bvalid = (i == 2); s_bready = (i == 2) ? 2'b10 : 2'b00;
            #1;
            check("cc_rvalid", s_rvalid, 2'b01);
            check("cc_rdata", s_rdata, 32'hD0 + 32'(i));
            check("cc_rlast", s_rlast, (i == 7) ? 1 : 0);
            if (i < 2) check("cc_wlast", m_axi_wlast, (i == 1) ? 1 : 0);
            if (i == 2) check("cc_bvalid", s_bvalid, 2'b10);
            step();
        end
        clear_inputs();
        #1;
        check_all_idle("cc_done");

        // long burst: 256 beats, WLAST only on the last
        s_awvalid = 2'b01; s_awaddr[0 +: AW] = 32'h6000_0000; s_awlen[7:0] = 8'd255;
        aw_phase(0, 8'd255, 32'h6000_0000);
        s_awvalid = 2'b00;
        w_phase(0, 8'd255, 32'h1000, 1'b0, cyc);
        b_phase(0, 2'b00);

        // reset mid-burst; tie pointers now favour requester 1 for both directions
        s_awvalid = 2'b01; s_awaddr[0 +: AW] = 32'h7000_0000; s_awlen[7:0] = 8'd3;
        s_arvalid = 2'b10; s_araddr[AW +: AW] = 32'h7100_0000;
        aw_phase(0, 8'd3, 32'h7000_0000);
        s_awvalid = 2'b00;
        check("rst_arvalid_pre", m_axi_arvalid, 1);
        s_wvalid = 2'b01; m_axi_wready = 1;
        step();
        #1;
        check("rst_beat2_wvalid", m_axi_wvalid, 1);
        aresetn = 0;
        #1;
        check_all_idle("rst_mid_burst");
        clear_inputs();
        step();
        aresetn = 1;
        s_awvalid = 2'b11; s_arvalid = 2'b11;
        #1;
        check_all_idle("rst_release");
        step();
        check("rst_aw_winner", {m_axi_awvalid, m_axi_awid}, {1'b1, 6'd0});
        check("rst_ar_winner", {m_axi_arvalid, m_axi_arid}, {1'b1, 6'd0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
